cache_write_buffer: RTL and testbench

CACHE_WRITE_BUFFER -- requirements
Module: cache_write_buffer

---
 rtl/cache_write_buffer.sv | 133 +++++++++++++
 tb/tb_cache_write_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_buffer.sv
// Line write buffer: circular FIFO with a two-state drain FSM; out_valid rises one cycle after a push; in_ready = !full, independent of out_ready.
// Define CACHE_WB_MERGE_EN to merge writes to the youngest entry's line when count>=2 (also accepted while full).
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 16
`endif
`ifndef CACHE_LINE_BIT_LENGTH
`define CACHE_LINE_BIT_LENGTH 128
`endif

module cache_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 28
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [ADDR_W-1:0]                 in_addr,
   input  logic [`CACHE_LINE_BIT_LENGTH-1:0] in_data,
   input  logic [`CACHE_LINE_SIZE-1:0]       in_strb,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ADDR_W-1:0]                 out_addr,
   output logic [`CACHE_LINE_BIT_LENGTH-1:0] out_data,
   output logic [`CACHE_LINE_SIZE-1:0]       out_strb,
   input  logic [ADDR_W-1:0]                 lookup_addr,
   output logic                              lookup_hit,
   output logic                              empty,
   output logic                              full
);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = `CACHE_LINE_BIT_LENGTH;
   localparam int SW = `CACHE_LINE_SIZE;
   localparam logic [PW:0] C_TWO  = 2;
   localparam logic [PW:0] C_FULL = DEPTH;

   typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DW-1:0]     r_data [DEPTH];
   logic [SW-1:0]     r_strb [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [PW-1:0]     r_head, r_tail, w_young;
   logic [PW:0]       r_count, w_count_nxt;
   logic              w_merge_ok, w_acc, w_push, w_merge, w_pop;
   logic [DW-1:0]     w_mask;

   assign w_young = r_tail - 1'b1;
`ifdef CACHE_WB_MERGE_EN
   assign w_merge_ok = (r_count >= C_TWO) && (r_addr[w_young] == in_addr);
`else
   assign w_merge_ok = 1'b0;
`endif

   assign full        = (r_count == C_FULL);
   assign empty       = (r_count == '0);
   assign in_ready    = !full || w_merge_ok;
   assign w_acc       = in_valid && in_ready;
   // zero-strobe writes complete the handshake but never allocate
   assign w_push      = w_acc && (|in_strb) && !w_merge_ok;
   assign w_merge     = w_acc && w_merge_ok;
   assign w_pop       = (r_state == S_SEND) && out_ready;
   assign w_count_nxt = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < SW; i++) w_mask[8*i +: 8] = {8{in_strb[i]}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + 1'b1;
         end
         if (w_push) begin
            r_vld[r_tail] <= 1'b1;
            r_tail        <= r_tail + 1'b1;
         end
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= in_addr;
         r_data[r_tail] <= in_data & w_mask;
         r_strb[r_tail] <= in_strb;
      end
      if (w_merge) begin
         r_data[w_young] <= (r_data[w_young] & ~w_mask) | (in_data & w_mask);
         r_strb[w_young] <= r_strb[w_young] | in_strb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_count_nxt != '0) w_state_nxt = S_SEND;
         S_SEND:  if (out_ready && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (r_state == S_SEND);
      out_addr  = '0;
      out_data  = '0;
      out_strb  = '0;
      if (out_valid) begin
         out_addr = r_addr[r_head];
         out_data = r_data[r_head];
         out_strb = r_strb[r_head];
      end
   end

   always_comb begin
      lookup_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (r_vld[i] && (r_addr[i] == lookup_addr)) lookup_hit = 1'b1;
   end
endmodule

// File: tb/tb_cache_write_buffer.sv
// Self-checking bench for cache_write_buffer against a queue-based reference model.
module tb_cache_write_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 28;
`ifdef CACHE_WB_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [AW-1:0] in_addr = '0, out_addr, lookup_addr = '0;
   logic [127:0]  in_data = '0, out_data;
   logic [15:0]   in_strb = '0, out_strb;
   logic          lookup_hit, empty, full;
   int            checks = 0, failures = 0;

   logic [AW-1:0] mq_addr [$];
   logic [127:0]  mq_data [$];
   logic [15:0]   mq_strb [$];

   always #5 clk = ~clk;

   cache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_strb(out_strb),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .empty(empty), .full(full)
   );

   function automatic logic [127:0] expand(input logic [15:0] s);
      logic [127:0] m;
      for (int i = 0; i < 16; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic bit m_merge(input logic [AW-1:0] a);
      if (!MERGE || mq_addr.size() < 2) return 1'b0;
      return mq_addr[mq_addr.size()-1] == a;
   endfunction

   function automatic bit m_ready(input logic [AW-1:0] a);
      return (mq_addr.size() < DEPTH) || m_merge(a);
   endfunction

   function automatic bit m_hit(input logic [AW-1:0] a);
      foreach (mq_addr[i]) if (mq_addr[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [AW-1:0] m_out_addr();
      return (mq_addr.size() > 0) ? mq_addr[0] : '0;
   endfunction
   function automatic logic [127:0] m_out_data();
      return (mq_data.size() > 0) ? mq_data[0] : '0;
   endfunction
   function automatic logic [15:0] m_out_strb();
      return (mq_strb.size() > 0) ? mq_strb[0] : '0;
   endfunction

   // Advance one clock: model sees the same inputs the DUT samples on the rising edge.
   task automatic tick();
      bit acc, mrg, pop;
      int k;
      acc = in_valid && m_ready(in_addr);
      mrg = m_merge(in_addr);
      pop = (mq_addr.size() > 0) && out_ready;
      @(posedge clk);
      if (pop) begin
         void'(mq_addr.pop_front());
         void'(mq_data.pop_front());
         void'(mq_strb.pop_front());
      end
      if (acc && in_strb != 16'h0) begin
         if (mrg) begin
            k = mq_addr.size() - 1;
            mq_data[k] = (mq_data[k] & ~expand(in_strb)) | (in_data & expand(in_strb));
            mq_strb[k] = mq_strb[k] | in_strb;
         end else begin
            mq_addr.push_back(in_addr);
            mq_data.push_back(in_data & expand(in_strb));
            mq_strb.push_back(in_strb);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      lookup_addr = 28'h10;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%0b%0b exp=10", empty, full); end
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_lookup_hit got=%0b exp=0", lookup_hit); end
      checks++; if (out_addr !== '0 || out_data !== '0 || out_strb !== '0) begin failures++; $display("FAIL reset_out_fields got=%0h/%0h/%0h exp=0", out_addr, out_data, out_strb); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      in_valid = 1'b1; in_addr = 28'h10; in_strb = 16'h0000; in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL zero_strb_alloc got empty=%0b vld=%0b exp empty=1 vld=0", empty, out_valid); end
      in_strb = 16'h000F; in_data = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_addr !== 28'h10) begin failures++; $display("FAIL basic_out got vld=%0b addr=%0h exp vld=1 addr=10", out_valid, out_addr); end
      checks++; if (out_strb !== 16'h000F) begin failures++; $display("FAIL basic_strb got=%0h exp=000f", out_strb); end
      checks++; if (out_data !== {96'h0, 32'hDEADBEEF}) begin failures++; $display("FAIL basic_data got=%0h exp=deadbeef", out_data); end
      tick();
      checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_pop got empty=%0b vld=%0b exp empty=1 vld=0", empty, out_valid); end
   endtask

   task automatic test_full_stall();
      logic [AW-1:0]  hold_addr, exp_addr [3];
      logic [127:0]   hold_data;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_addr = AW'(28'h101 + i); in_strb = 16'($urandom) | 16'h1;
         in_data = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      in_addr = 28'h200; in_strb = 16'hFFFF;
      checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL full_flags got full=%0b rdy=%0b exp full=1 rdy=0", full, in_ready); end
      hold_addr = out_addr; hold_data = out_data;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (out_addr !== 28'h101 || hold_addr !== 28'h101 || out_data !== hold_data || out_data !== m_out_data()) begin
         failures++; $display("FAIL stall_stable got addr=%0h data=%0h exp addr=101 data=%0h", out_addr, out_data, m_out_data()); end
      out_ready = 1'b1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_indep got=%0b exp=0", in_ready); end
      tick();
      checks++; if (full !== 1'b0 || in_ready !== 1'b1 || out_addr !== 28'h102) begin
         failures++; $display("FAIL pop_only got full=%0b rdy=%0b addr=%0h exp 0/1/102", full, in_ready, out_addr); end
      tick();
      in_valid = 1'b0;
      exp_addr[0] = 28'h103; exp_addr[1] = 28'h104; exp_addr[2] = 28'h200;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1 || out_addr !== exp_addr[i] || out_strb !== m_out_strb()) begin
            failures++; $display("FAIL drain_order[%0d] got vld=%0b addr=%0h exp addr=%0h", i, out_valid, out_addr, exp_addr[i]); end
         tick();
      end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_lookup();
      out_ready = 1'b0; lookup_addr = 28'h20;
      in_valid = 1'b1; in_addr = 28'h20; in_strb = 16'h00F0; in_data = {$urandom, $urandom, $urandom, $urandom};
      checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL lookup_before got=%0b exp=0", lookup_hit); end
      tick();
      in_valid = 1'b0;
      checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL lookup_pending got=%0b exp=1", lookup_hit); end
      out_ready = 1'b1;
      checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL lookup_pop_cycle got=%0b exp=1", lookup_hit); end
      tick();
      checks++; if (lookup_hit !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL lookup_after got hit=%0b empty=%0b exp 0/1", lookup_hit, empty); end
   endtask

   task automatic test_merge();
      int pops;
      logic [15:0] second_strb;
      out_ready = 1'b0; pops = 0; second_strb = '0;
      in_valid = 1'b1;
      in_addr = 28'h30; in_strb = 16'h000F; in_data = {$urandom, $urandom, $urandom, $urandom}; tick();
      in_addr = 28'h40; in_strb = 16'h000F; in_data = {$urandom, $urandom, $urandom, $urandom}; tick();
      in_addr = 28'h40; in_strb = 16'h00F0; in_data = {$urandom, $urandom, $urandom, $urandom}; tick();
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid === 1'b1) begin
            pops++;
            if (pops == 2) second_strb = out_strb;
            checks++; if (out_data !== m_out_data()) begin failures++; $display("FAIL merge_data[%0d] got=%0h exp=%0h", i, out_data, m_out_data()); end
         end
         tick();
      end
      checks++; if (pops != (MERGE ? 2 : 3)) begin failures++; $display("FAIL merge_count got=%0d exp=%0d", pops, MERGE ? 2 : 3); end
      checks++; if (second_strb !== (MERGE ? 16'h00FF : 16'h000F)) begin failures++; $display("FAIL merge_strb got=%0h exp=%0h", second_strb, MERGE ? 16'h00FF : 16'h000F); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         in_addr     = AW'($urandom_range(0, 5));
         in_strb     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         in_data     = {$urandom, $urandom, $urandom, $urandom};
         lookup_addr = AW'($urandom_range(0, 6));
         #1;
         checks++; if (out_valid !== (mq_addr.size() > 0)) begin failures++; $display("FAIL rnd_out_valid c=%0d got=%0b exp=%0b", c, out_valid, mq_addr.size() > 0); end
         checks++; if (out_addr !== m_out_addr() || out_strb !== m_out_strb()) begin failures++; $display("FAIL rnd_out_as c=%0d got=%0h/%0h exp=%0h/%0h", c, out_addr, out_strb, m_out_addr(), m_out_strb()); end
         checks++; if (out_data !== m_out_data()) begin failures++; $display("FAIL rnd_out_data c=%0d got=%0h exp=%0h", c, out_data, m_out_data()); end
         checks++; if (in_ready !== m_ready(in_addr)) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, m_ready(in_addr)); end
         checks++; if (full !== (mq_addr.size() == DEPTH) || empty !== (mq_addr.size() == 0)) begin failures++; $display("FAIL rnd_full_empty c=%0d got=%0b%0b size=%0d", c, full, empty, mq_addr.size()); end
         checks++; if (lookup_hit !== m_hit(lookup_addr)) begin failures++; $display("FAIL rnd_lookup c=%0d got=%0b exp=%0b", c, lookup_hit, m_hit(lookup_addr)); end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_strb = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         in_addr = AW'(28'h50 + i); in_data = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      in_valid = 1'b0; lookup_addr = 28'h50;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL async_reset got vld=%0b empty=%0b exp 0/1", out_valid, empty); end
      checks++; if (lookup_hit !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_hit got hit=%0b rdy=%0b exp 0/1", lookup_hit, in_ready); end
      mq_addr.delete(); mq_data.delete(); mq_strb.delete();
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_pop[%0d] got=%0b exp=0", i, out_valid); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_stall();
      test_lookup();
      test_merge();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
